// File: rtl/online_mult_pkg.sv
// Purpose: shared signed-digit encodings and digit-pair type for the online multiplier.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package online_mult_pkg;

    // Signed-digit code is {plus, minus}; both bits set has no legal meaning.
    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_BAD  = 2'b11;

    typedef struct packed {
        logic [1:0] x;
        logic [1:0] y;
    } digit_pair_t;

    function automatic logic sd_is_bad(input logic [1:0] d);
        return (d == SD_BAD);
    endfunction

    // Illegal code is stored as zero so the datapath never sees +1 and -1 at once.
    function automatic logic [1:0] sd_sanitize(input logic [1:0] d);
        return sd_is_bad(d) ? SD_ZERO : d;
    endfunction

endpackage

// File: rtl/online_digit_slot.sv
// Purpose: one slot's x/y signed-digit prefix history plus its digit counter.
// Latency: state updates at the edge; next-state values are exported for write-through readout.
// Backpressure: none here; writes at a full count are ignored, the parent gates acceptance.
//
// Ports: clk/rst (sync, active-high), clr_i clears history and counter, wr_i stores pair_i
// at the next MSB-first position; *_d_o expose next-state vectors, cnt_q_o/cnt_d_o the counter.
module online_digit_slot
    import online_mult_pkg::*;
#(
    parameter int NUM_DIGITS = 16,
    parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_i,
    input  digit_pair_t           pair_i,
    output logic [NUM_DIGITS-1:0] xp_d_o,
    output logic [NUM_DIGITS-1:0] xm_d_o,
    output logic [NUM_DIGITS-1:0] yp_d_o,
    output logic [NUM_DIGITS-1:0] ym_d_o,
    output logic [CNT_W-1:0]      cnt_q_o,
    output logic [CNT_W-1:0]      cnt_d_o
);

    logic [NUM_DIGITS-1:0] xp_q, xm_q, yp_q, ym_q;
    logic [NUM_DIGITS-1:0] xp_d, xm_d, yp_d, ym_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    always_comb begin
        xp_d  = xp_q;
        xm_d  = xm_q;
        yp_d  = yp_q;
        ym_d  = ym_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            xp_d  = '0;
            xm_d  = '0;
            yp_d  = '0;
            ym_d  = '0;
            cnt_d = '0;
        end else if (wr_i && (cnt_q != CNT_W'(NUM_DIGITS))) begin
            // Digit k lands at bit NUM_DIGITS-1-k: first digit is the MSB.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cnt_q == CNT_W'(NUM_DIGITS - 1 - i)) begin
                    xp_d[i] = pair_i.x[1];
                    xm_d[i] = pair_i.x[0];
                    yp_d[i] = pair_i.y[1];
                    ym_d[i] = pair_i.y[0];
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xp_q  <= '0;
            xm_q  <= '0;
            yp_q  <= '0;
            ym_q  <= '0;
            cnt_q <= '0;
        end else begin
            xp_q  <= xp_d;
            xm_q  <= xm_d;
            yp_q  <= yp_d;
            ym_q  <= ym_d;
            cnt_q <= cnt_d;
        end
    end

    assign xp_d_o  = xp_d;
    assign xm_d_o  = xm_d;
    assign yp_d_o  = yp_d;
    assign ym_d_o  = ym_d;
    assign cnt_q_o = cnt_q;
    assign cnt_d_o = cnt_d;

endmodule

// File: rtl/online_digit_history.sv
// Purpose: multi-slot store of serial signed-digit x/y streams, presenting the selected slot's prefixes.
// Latency: 1 cycle from accept, clear or slot change to registered outputs (write-through).
// Backpressure: in_ready drops combinationally during rst/start or when the addressed slot is full.
//
// Ports: clk, rst (sync, active-high); start clears the addressed slot; slot selects write/clear/readout;
// in_valid/in_ready digit handshake with x_digit/y_digit ({plus,minus}); x_/y_ plus/minus prefix
// vectors, digit_cnt, full of the selected slot; out_valid and digit_err one-cycle pulses.
module online_digit_history
    import online_mult_pkg::*;
#(
    parameter int  NUM_DIGITS = 16,
    parameter int  NUM_SLOTS  = 8,
    localparam int SLOT_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    localparam int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SLOT_W-1:0]     slot,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            x_digit,
    input  logic [1:0]            y_digit,
    output logic [NUM_DIGITS-1:0] x_plus,
    output logic [NUM_DIGITS-1:0] x_minus,
    output logic [NUM_DIGITS-1:0] y_plus,
    output logic [NUM_DIGITS-1:0] y_minus,
    output logic [CNT_W-1:0]      digit_cnt,
    output logic                  full,
    output logic                  out_valid,
    output logic                  digit_err
);

    logic [NUM_DIGITS-1:0] xp_d [NUM_SLOTS];
    logic [NUM_DIGITS-1:0] xm_d [NUM_SLOTS];
    logic [NUM_DIGITS-1:0] yp_d [NUM_SLOTS];
    logic [NUM_DIGITS-1:0] ym_d [NUM_SLOTS];
    logic [CNT_W-1:0]      cnt_q [NUM_SLOTS];
    logic [CNT_W-1:0]      cnt_d [NUM_SLOTS];

    logic [NUM_DIGITS-1:0] sel_xp_d, sel_xm_d, sel_yp_d, sel_ym_d;
    logic [CNT_W-1:0]      sel_cnt_q, sel_cnt_d;

    logic                  accept;
    logic                  bad_digit;
    digit_pair_t           pair;

    logic [NUM_DIGITS-1:0] x_plus_q, x_minus_q, y_plus_q, y_minus_q;
    logic [CNT_W-1:0]      digit_cnt_q;
    logic                  full_q, out_valid_q, digit_err_q;

    assign pair.x    = sd_sanitize(x_digit);
    assign pair.y    = sd_sanitize(y_digit);
    assign bad_digit = sd_is_bad(x_digit) || sd_is_bad(y_digit);

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        online_digit_slot #(
            .NUM_DIGITS (NUM_DIGITS),
            .CNT_W      (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr_i   (start && (slot == SLOT_W'(s))),
            .wr_i    (accept && (slot == SLOT_W'(s))),
            .pair_i  (pair),
            .xp_d_o  (xp_d[s]),
            .xm_d_o  (xm_d[s]),
            .yp_d_o  (yp_d[s]),
            .ym_d_o  (ym_d[s]),
            .cnt_q_o (cnt_q[s]),
            .cnt_d_o (cnt_d[s])
        );
    end

    // Addressed-slot mux: live count drives in_ready, next-state values feed the output register.
    always_comb begin
        sel_xp_d  = '0;
        sel_xm_d  = '0;
        sel_yp_d  = '0;
        sel_ym_d  = '0;
        sel_cnt_q = '0;
        sel_cnt_d = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot == SLOT_W'(s)) begin
                sel_xp_d  = xp_d[s];
                sel_xm_d  = xm_d[s];
                sel_yp_d  = yp_d[s];
                sel_ym_d  = ym_d[s];
                sel_cnt_q = cnt_q[s];
                sel_cnt_d = cnt_d[s];
            end
        end
    end

    // start wins over a simultaneous digit, which is simply dropped.
    assign in_ready = !rst && !start && (sel_cnt_q != CNT_W'(NUM_DIGITS));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_plus_q    <= '0;
            x_minus_q   <= '0;
            y_plus_q    <= '0;
            y_minus_q   <= '0;
            digit_cnt_q <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            digit_err_q <= 1'b0;
        end else begin
            x_plus_q    <= sel_xp_d;
            x_minus_q   <= sel_xm_d;
            y_plus_q    <= sel_yp_d;
            y_minus_q   <= sel_ym_d;
            digit_cnt_q <= sel_cnt_d;
            full_q      <= (sel_cnt_d == CNT_W'(NUM_DIGITS));
            out_valid_q <= accept;
            digit_err_q <= accept && bad_digit;
        end
    end

    assign x_plus    = x_plus_q;
    assign x_minus   = x_minus_q;
    assign y_plus    = y_plus_q;
    assign y_minus   = y_minus_q;
    assign digit_cnt = digit_cnt_q;
    assign full      = full_q;
    assign out_valid = out_valid_q;
    assign digit_err = digit_err_q;

endmodule

// File: tb/tb_online_digit_history.sv
// Purpose: self-checking bench for online_digit_history (NUM_DIGITS=4, NUM_SLOTS=4).
// Latency: expected outputs queued at drive time, compared 1 cycle later.
// Backpressure: in_ready checked against the bench model before every edge.
module tb_online_digit_history;

    localparam int ND = 4;
    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [1:0] slot, x_digit, y_digit;
    logic       in_ready;
    logic [ND-1:0] x_plus, x_minus, y_plus, y_minus;
    logic [2:0] digit_cnt;
    logic       full, out_valid, digit_err;

    online_digit_history #(.NUM_DIGITS(ND), .NUM_SLOTS(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .slot      (slot),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_digit   (x_digit),
        .y_digit   (y_digit),
        .x_plus    (x_plus),
        .x_minus   (x_minus),
        .y_plus    (y_plus),
        .y_minus   (y_minus),
        .digit_cnt (digit_cnt),
        .full      (full),
        .out_valid (out_valid),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] xp, xm, yp, ym;
        logic [2:0]    cnt;
        logic          full, ov, err;
    } exp_t;

    exp_t q[$];

    // Reference model of every slot.
    logic [ND-1:0] m_xp [NS];
    logic [ND-1:0] m_xm [NS];
    logic [ND-1:0] m_yp [NS];
    logic [ND-1:0] m_ym [NS];
    int            m_cnt [NS];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic clear_slot(input int s);
        m_xp[s] = '0; m_xm[s] = '0; m_yp[s] = '0; m_ym[s] = '0; m_cnt[s] = 0;
    endtask

    // Drive one cycle of stimulus, check in_ready, queue expectations, then compare after the edge.
    task automatic step(input logic r, input logic st, input logic [1:0] sl,
                        input logic v, input logic [1:0] xd, input logic [1:0] yd);
        exp_t       e;
        exp_t       got;
        logic       rdy_e;
        logic [1:0] xs, ys;
        int         pos;
        rst = r; start = st; slot = sl; in_valid = v; x_digit = xd; y_digit = yd;
        #2;
        rdy_e = !r && !st && (m_cnt[sl] != ND);
        chk("in_ready", {31'b0, in_ready}, {31'b0, rdy_e});
        e.ov  = 1'b0;
        e.err = 1'b0;
        if (r) begin
            for (int s = 0; s < NS; s++) clear_slot(s);
        end else if (st) begin
            clear_slot(sl);
        end else if (v && rdy_e) begin
            xs  = (xd == 2'b11) ? 2'b00 : xd;
            ys  = (yd == 2'b11) ? 2'b00 : yd;
            pos = ND - 1 - m_cnt[sl];
            m_xp[sl][pos] = xs[1];
            m_xm[sl][pos] = xs[0];
            m_yp[sl][pos] = ys[1];
            m_ym[sl][pos] = ys[0];
            m_cnt[sl]++;
            e.ov  = 1'b1;
            e.err = (xd == 2'b11) || (yd == 2'b11);
        end
        e.xp   = m_xp[sl];
        e.xm   = m_xm[sl];
        e.yp   = m_yp[sl];
        e.ym   = m_ym[sl];
        e.cnt  = 3'(m_cnt[sl]);
        e.full = (m_cnt[sl] == ND);
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        chk("x_plus",    {28'b0, x_plus},    {28'b0, got.xp});
        chk("x_minus",   {28'b0, x_minus},   {28'b0, got.xm});
        chk("y_plus",    {28'b0, y_plus},    {28'b0, got.yp});
        chk("y_minus",   {28'b0, y_minus},   {28'b0, got.ym});
        chk("digit_cnt", {29'b0, digit_cnt}, {29'b0, got.cnt});
        chk("full",      {31'b0, full},      {31'b0, got.full});
        chk("out_valid", {31'b0, out_valid}, {31'b0, got.ov});
        chk("digit_err", {31'b0, digit_err}, {31'b0, got.err});
    endtask

    initial begin
        for (int s = 0; s < NS; s++) clear_slot(s);
        rst = 1'b1; start = 1'b0; slot = '0; in_valid = 1'b0; x_digit = '0; y_digit = '0;
        @(posedge clk);
        #1;

        // Reset: two cycles, then idle with in_ready high.
        step(1'b1, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00);
        step(1'b1, 1'b0, 2'd0, 1'b1, 2'b10, 2'b10);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00);

        // Single-stream fill of slot 0.
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 2'b01);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b01, 2'b01);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b00, 2'b10);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 2'b00);
        chk("fill_x_plus",  {28'b0, x_plus},  32'h9);
        chk("fill_x_minus", {28'b0, x_minus}, 32'h4);
        chk("fill_y_plus",  {28'b0, y_plus},  32'h2);
        chk("fill_y_minus", {28'b0, y_minus}, 32'hC);
        chk("fill_cnt",     {29'b0, digit_cnt}, 32'd4);
        chk("fill_full",    {31'b0, full},    32'd1);
        // Fifth digit on a full slot is refused.
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b01, 2'b01);
        chk("fifth_cnt",    {29'b0, digit_cnt}, 32'd4);

        // Illegal digit into empty slot 1.
        step(1'b0, 1'b0, 2'd1, 1'b1, 2'b11, 2'b10);
        chk("bad_err",      {31'b0, digit_err}, 32'd1);
        chk("bad_xp3",      {31'b0, x_plus[3]}, 32'd0);
        chk("bad_xm3",      {31'b0, x_minus[3]}, 32'd0);
        chk("bad_yp3",      {31'b0, y_plus[3]}, 32'd1);
        chk("bad_cnt",      {29'b0, digit_cnt}, 32'd1);
        step(1'b0, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00);

        // Clear slots 0 and 1 (slot 0 clear also carries a digit that must be dropped).
        step(1'b0, 1'b1, 2'd0, 1'b1, 2'b10, 2'b10);
        step(1'b0, 1'b1, 2'd1, 1'b0, 2'b00, 2'b00);

        // Interleave slots 0/1, three digits each.
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 2'b00);
        step(1'b0, 1'b0, 2'd1, 1'b1, 2'b01, 2'b10);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b10, 2'b01);
        step(1'b0, 1'b0, 2'd1, 1'b1, 2'b00, 2'b10);
        step(1'b0, 1'b0, 2'd0, 1'b1, 2'b01, 2'b10);
        step(1'b0, 1'b0, 2'd1, 1'b1, 2'b10, 2'b11);
        step(1'b0, 1'b0, 2'd0, 1'b0, 2'b00, 2'b00);
        chk("il0_x_plus",  {28'b0, x_plus},  32'hC);
        chk("il0_x_minus", {28'b0, x_minus}, 32'h2);
        chk("il0_y_plus",  {28'b0, y_plus},  32'h2);
        chk("il0_y_minus", {28'b0, y_minus}, 32'h4);
        chk("il0_cnt",     {29'b0, digit_cnt}, 32'd3);
        step(1'b0, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00);
        chk("il1_x_plus",  {28'b0, x_plus},  32'h2);
        chk("il1_x_minus", {28'b0, x_minus}, 32'h8);
        chk("il1_y_plus",  {28'b0, y_plus},  32'hC);
        chk("il1_y_minus", {28'b0, y_minus}, 32'h0);
        chk("il1_cnt",     {29'b0, digit_cnt}, 32'd3);

        // start with in_valid on slot 2 holding two digits.
        step(1'b0, 1'b0, 2'd2, 1'b1, 2'b10, 2'b01);
        step(1'b0, 1'b0, 2'd2, 1'b1, 2'b01, 2'b10);
        step(1'b0, 1'b1, 2'd2, 1'b1, 2'b10, 2'b10);
        chk("clr_cnt",     {29'b0, digit_cnt}, 32'd0);
        chk("clr_x_plus",  {28'b0, x_plus},  32'h0);
        chk("clr_ov",      {31'b0, out_valid}, 32'd0);

        // Mid-stream reset after two digits in slot 3.
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'b01, 2'b01);
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'b10, 2'b10);
        step(1'b1, 1'b0, 2'd3, 1'b0, 2'b00, 2'b00);
        step(1'b0, 1'b0, 2'd3, 1'b1, 2'b10, 2'b01);
        chk("rst_x_plus",  {28'b0, x_plus},  32'h8);
        chk("rst_y_minus", {28'b0, y_minus}, 32'h8);
        chk("rst_cnt",     {29'b0, digit_cnt}, 32'd1);
        step(1'b0, 1'b0, 2'd1, 1'b0, 2'b00, 2'b00);
        chk("rst_slot1_cnt", {29'b0, digit_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/online_digit_history.md
Name: online_digit_history

Overview:
- Parametrised successor of the per-cycle x/y digit store for the online multiplier.
- Accumulates the serial signed-digit operand streams x and y (plus/minus bit pairs, most significant digit first) into per-slot history registers.
- Presents the full digit-prefix vectors x_plus/x_minus/y_plus/y_minus of the selected slot to the online multiply datapath.
- Replaces the external-RAM read-modify-write scheme with internal registers:
  - parametrised digit count and slot count;
  - per-slot digit counters;
  - valid/ready handshake, slot clear, full detection, invalid-digit detection.

Parameters:
- NUM_DIGITS, 16, digits per operand history (precision); must be >= 2.
- NUM_SLOTS, 8, independent computation slots (interleaved computations); power of two, >= 1.
- SLOT_W, $clog2(NUM_SLOTS) (min 1), slot index width (derived).
- CNT_W, $clog2(NUM_DIGITS+1), digit counter width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  clear the slot addressed by slot (history and counter).
- slot  in  SLOT_W  selected computation slot for write, clear and readout.
- in_valid  in  1  x_digit/y_digit carry a new digit pair.
- in_ready  out  1  block can accept a digit pair this cycle (combinational).
- x_digit  in  2  {plus,minus} of x digit.
- y_digit  in  2  {plus,minus} of y digit.
- x_plus  out  NUM_DIGITS  plus bits of x prefix, selected slot.
- x_minus  out  NUM_DIGITS  minus bits of x prefix, selected slot.
- y_plus  out  NUM_DIGITS  plus bits of y prefix, selected slot.
- y_minus  out  NUM_DIGITS  minus bits of y prefix, selected slot.
- digit_cnt  out  CNT_W  digits held by selected slot.
- full  out  1  selected slot holds NUM_DIGITS digits.
- out_valid  out  1  one-cycle pulse: outputs include a newly accepted digit.
- digit_err  out  1  one-cycle pulse: accepted digit pair contained code 2'b11.

Behaviour:
- Reset: all slot histories, all slot counters, and all registered outputs (prefix vectors, digit_cnt, full, out_valid, digit_err) = 0. Reset mid-stream discards all slots; no partial state survives.
- in_ready = !rst && !start && !cnt[slot]==NUM_DIGITS, i.e. !full of the addressed slot, computed from current state.
- Accept condition: in_valid && in_ready.
- On accept into slot s with count k:
  - x digit stored at bit NUM_DIGITS-1-k of x_plus/x_minus; y digit likewise.
  - First digit becomes MSB; this matches the datapath's prefix order.
  - cnt[s] <= k+1.
- Digit code 2'b11 is not a legal signed digit:
  - stored as 2'b00 (value zero);
  - still counted;
  - digit_err = 1 in the next cycle. Each operand is checked independently; the pulse is ORed.
- start: slot history <= 0 and cnt <= 0 at the edge. start has priority over a simultaneous in_valid: the digit is dropped and in_ready is 0 in that cycle. Other slots are untouched.
- Outputs are registered and write-through. After edge t they show the slot addressed at t, including any digit accepted or clear done at t. Latency: 1 cycle from accept or slot change to visible outputs.
- full is registered alongside the outputs; it reflects the slot addressed in the previous cycle. in_ready uses the live count, so there is no overrun.
- Full slot with in_valid: in_ready = 0; no state change; no out_valid.
- Slot switching between digits is legal every cycle. Counters are per slot, so interleaved streams fill independently.
- out_valid = 1 in the cycle after an accept, otherwise 0.
- No wrap-around: after NUM_DIGITS digits the slot stays full until start or rst.

Decomposition:
- Shared package (online_mult_pkg):
  - signed-digit encodings SD_ZERO=2'b00, SD_NEG=2'b01, SD_POS=2'b10, SD_BAD=2'b11;
  - digit pair typedef {x[1:0], y[1:0]}.
- Sub-module: online_digit_slot. Holds one slot's 4*NUM_DIGITS bits and its counter; has clear/write inputs; instantiated NUM_SLOTS times.
- Top level contains the handshake, the digit sanitise/err logic, and the output mux and register.

Test Plan:
- Reset check: rst=1 for 2 cycles -> all outputs 0, in_ready=1.
- Single-stream fill, NUM_DIGITS=4, slot 0: digits x=10,01,00,10 and y=01,01,10,00 -> x_plus=4'b1001, x_minus=4'b0100, y_plus=4'b0010, y_minus=4'b1100, digit_cnt=4, full=1, in_ready=0. A fifth in_valid is ignored.
- Illegal digit: slot 1 empty, x_digit=11, y_digit=10 -> digit_err=1 for one cycle; x_plus[3]=0, x_minus[3]=0, y_plus[3]=1, digit_cnt=1.
- Interleave: alternate slot 0/1 every cycle, 3 digits each -> each slot digit_cnt=3 with its own pattern; no cross-contamination.
- start with in_valid on a slot holding 2 digits -> digit dropped, in_ready=0 that cycle; next cycle all vectors 0, digit_cnt=0, out_valid=0.
- Mid-stream rst after 2 digits in slot 3 -> slot 3 empty; the next accepted digit lands at MSB position.
